// File: rtl/pe_alu_pkg.sv
// Shared definitions for the PE ALU tile: opcode encodings used by the tile
// and the issue controller's FSM state type.
package pe_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_SEL = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/pe_result_reg.sv
// One-entry valid/ready output register. A load and an unload in the same
// cycle replace the entry without a bubble.
module pe_result_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_space,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign o_space = !r_valid || i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_alu_issue.sv
// Issue/retire controller for the PE's combinational ALU: joins two operand
// channels, captures the ALU result, and optionally runs a fixed-length reduction.
module pe_alu_issue
  import pe_alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    in1_data,
  input  logic                in1_valid,
  output logic                in1_ready,
  input  logic [WIDTH-1:0]    in2_data,
  input  logic                in2_sel,
  input  logic                in2_valid,
  output logic                in2_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    alu_in1,
  output logic [WIDTH-1:0]    alu_in2,
  output logic                alu_in3,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                acc_mode,
  input  logic [LEN_BITS-1:0] acc_len
);

  state_t              r_state;
  logic [WIDTH-1:0]    r_acc;
  logic [LEN_BITS-1:0] r_cnt;

  logic                w_space;
  logic                w_both;
  logic                w_single;
  logic                w_last;
  logic                w_load;
  logic                w_seed;
  logic                w_step;
  logic [LEN_BITS-1:0] w_eff_len;

  assign w_eff_len = (acc_len == '0) ? LEN_BITS'(1) : acc_len;
  // A one-beat reduction is indistinguishable from a plain operand pair.
  assign w_single  = !acc_mode || (w_eff_len == LEN_BITS'(1));
  assign w_both    = in1_valid && in2_valid;
  assign w_last    = (r_cnt == (w_eff_len - LEN_BITS'(1)));

  assign alu_in1 = (r_state == ACC) ? r_acc : in1_data;
  assign alu_in2 = in2_data;
  assign alu_in3 = in2_sel;

  always_comb begin
    in1_ready = 1'b0;
    in2_ready = 1'b0;
    w_load    = 1'b0;
    w_seed    = 1'b0;
    w_step    = 1'b0;
    if (r_state == IDLE) begin
      if (w_single) begin
        in1_ready = w_both && w_space;
        in2_ready = w_both && w_space;
        w_load    = w_both && w_space;
      end else begin
        // Seed beat only feeds the accumulator, so it needs no output space.
        in1_ready = w_both;
        in2_ready = w_both;
        w_seed    = w_both;
      end
    end else begin
      if (w_last) begin
        in2_ready = in2_valid && w_space;
        w_load    = in2_valid && w_space;
      end else begin
        in2_ready = in2_valid;
        w_step    = in2_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_seed) begin
      r_state <= ACC;
      r_acc   <= alu_result;
      r_cnt   <= LEN_BITS'(1);
    end else if (w_step) begin
      r_acc   <= alu_result;
      r_cnt   <= r_cnt + LEN_BITS'(1);
    end else if (w_load && (r_state == ACC)) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end
  end

  pe_result_reg #(
    .WIDTH(WIDTH)
  ) u_result_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (alu_result),
    .o_space (w_space),
    .o_data  (out_data),
    .o_valid (out_valid),
    .i_ready (out_ready)
  );

endmodule

// File: tb/tb_pe_alu_issue.sv
// Randomized scoreboard bench for pe_alu_issue with a stand-in ALU
// (sel=0 add, sel=1 xor) and a reduction-level reference model.
module tb_pe_alu_issue;

  localparam int WIDTH    = 32;
  localparam int LEN_BITS = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [WIDTH-1:0]    in1_data;
  logic                in1_valid;
  logic                in1_ready;
  logic [WIDTH-1:0]    in2_data;
  logic                in2_sel;
  logic                in2_valid;
  logic                in2_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    alu_in1;
  logic [WIDTH-1:0]    alu_in2;
  logic                alu_in3;
  logic [WIDTH-1:0]    alu_result;
  logic                acc_mode;
  logic [LEN_BITS-1:0] acc_len;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit               rdy_random = 1'b0;

  always #5 clk = ~clk;

  assign alu_result = alu_in3 ? (alu_in1 ^ alu_in2) : (alu_in1 + alu_in2);

  pe_alu_issue #(
    .WIDTH(WIDTH),
    .LEN_BITS(LEN_BITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1_data   (in1_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in2_data   (in2_data),
    .in2_sel    (in2_sel),
    .in2_valid  (in2_valid),
    .in2_ready  (in2_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_in3    (alu_in3),
    .alu_result (alu_result),
    .acc_mode   (acc_mode),
    .acc_len    (acc_len)
  );

  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic s);
    return s ? (a ^ b) : (a + b);
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Waits (bounded) for an input handshake seen at the falling edge.
  task automatic wait_hs(input bit need1, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (in2_ready && (!need1 || in1_ready)) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no handshake expected handshake", name);
    end
  endtask

  task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                           input int d2);
    in1_data  = a;
    in1_valid = 1'b1;
    for (int i = 0; i < d2; i++) begin
      @(negedge clk);
      check1("join_in1_ready", in1_ready, 1'b0);
      check1("join_in2_ready", in2_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    in2_data  = b;
    in2_sel   = s;
    in2_valid = 1'b1;
    wait_hs(1'b1, "pair");
    exp_q.push_back(ref_op(a, b, s));
    @(posedge clk);
    #1;
    in1_valid = 1'b0;
    in2_valid = 1'b0;
  endtask

  task automatic send_reduce(input logic [WIDTH-1:0] a, input int len, input bit seq, input bit gaps);
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] acc;
    int               eff;
    eff      = (len == 0) ? 1 : len;
    acc_mode = 1'b1;
    acc_len  = LEN_BITS'(len);
    b        = seq ? 1 : $urandom;
    s        = seq ? 1'b0 : 1'($urandom_range(0, 1));
    acc      = ref_op(a, b, s);
    in1_data  = a;
    in1_valid = 1'b1;
    in2_data  = b;
    in2_sel   = s;
    in2_valid = 1'b1;
    wait_hs(1'b1, "seed");
    if (eff == 1) exp_q.push_back(acc);
    @(posedge clk);
    #1;
    for (int i = 1; i < eff; i++) begin
      // Operand 1 stays offered during accumulation and must be ignored.
      in1_data  = $urandom;
      in1_valid = 1'b1;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in2_valid = 1'b0;
        @(negedge clk);
        check1("acc_gap_in1_ready", in1_ready, 1'b0);
        @(posedge clk);
        #1;
      end
      b         = seq ? WIDTH'(i + 1) : $urandom;
      s         = seq ? 1'b0 : 1'($urandom_range(0, 1));
      acc       = ref_op(acc, b, s);
      in2_data  = b;
      in2_sel   = s;
      in2_valid = 1'b1;
      wait_hs(1'b0, "acc_beat");
      check1("acc_in1_ready", in1_ready, 1'b0);
      if (i == eff - 1) exp_q.push_back(acc);
      @(posedge clk);
      #1;
    end
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    acc_mode  = 1'b0;
  endtask

  // Monitor: every output transfer pops one expected result.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          $display("result %0h expected %0h", out_data, e);
          check("result", out_data, e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_random) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst_n     = 1'b0;
    in1_data  = '0;
    in1_valid = 1'b0;
    in2_data  = '0;
    in2_sel   = 1'b0;
    in2_valid = 1'b0;
    out_ready = 1'b0;
    acc_mode  = 1'b0;
    acc_len   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, '0);
    check1("reset_in1_ready", in1_ready, 1'b0);
    check1("reset_in2_ready", in2_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back ADD pairs: one result per cycle, one cycle of latency.
    out_ready = 1'b1;
    in1_data  = 32'd3;
    in2_data  = 32'd4;
    in2_sel   = 1'b0;
    in1_valid = 1'b1;
    in2_valid = 1'b1;
    wait_hs(1'b1, "add1");
    exp_q.push_back(32'd7);
    @(posedge clk);
    #1;
    in1_data = 32'd10;
    in2_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check1("lat_out_valid", out_valid, 1'b1);
    check("lat_out_data", out_data, 32'd7);
    check1("thru_in1_ready", in1_ready, 1'b1);
    exp_q.push_back(32'd9);
    @(posedge clk);
    #1;
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    @(negedge clk);
    check1("second_out_valid", out_valid, 1'b1);
    check("second_out_data", out_data, 32'd9);
    @(posedge clk);
    #1;

    // Backpressure: one result held, inputs stalled, then resume.
    out_ready = 1'b0;
    in1_data  = 32'd5;
    in2_data  = 32'd6;
    in1_valid = 1'b1;
    in2_valid = 1'b1;
    wait_hs(1'b1, "bp_first");
    exp_q.push_back(32'd11);
    @(posedge clk);
    #1;
    in1_data = 32'd7;
    in2_data = 32'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("bp_in1_ready", in1_ready, 1'b0);
      check1("bp_in2_ready", in2_ready, 1'b0);
      check1("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, 32'd11);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check1("bp_resume_ready", in1_ready, 1'b1);
    exp_q.push_back(32'd15);
    @(posedge clk);
    #1;
    in1_valid = 1'b0;
    in2_valid = 1'b0;

    // Join: operand 1 alone for 4 cycles.
    send_pair(32'd20, 32'd22, 1'b0, 4);

    // Directed reduction 0+1+2+3+4 and degenerate lengths.
    send_reduce(32'd0, 4, 1'b1, 1'b0);
    send_reduce($urandom, 0, 1'b0, 1'b0);
    send_reduce($urandom, 1, 1'b0, 1'b0);

    rdy_random = 1'b1;
    for (int n = 0; n < 40; n++)
      send_pair($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    for (int n = 0; n < 12; n++)
      send_reduce($urandom, $urandom_range(0, 9), 1'b0, 1'b1);
    send_reduce($urandom, 255, 1'b0, 1'b0);

    rdy_random = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;

    // Reset mid-reduction with a pending output: both are discarded.
    out_ready = 1'b0;
    send_pair(32'd1, 32'd1, 1'b0, 0);
    acc_mode  = 1'b1;
    acc_len   = LEN_BITS'(5);
    in1_data  = 32'd1;
    in2_data  = 32'd2;
    in2_sel   = 1'b0;
    in1_valid = 1'b1;
    in2_valid = 1'b1;
    wait_hs(1'b1, "rst_seed");
    @(posedge clk);
    #1;
    in2_data = 32'd3;
    wait_hs(1'b0, "rst_beat");
    @(posedge clk);
    #1;
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check1("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, '0);
    check1("midrst_in1_ready", in1_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_reduce(32'd5, 3, 1'b1, 1'b0);
    send_pair(32'd100, 32'd23, 1'b0, 0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    check("queue_empty", WIDTH'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
